// File: rtl/mips_trace_pkg.sv
// Shared types, entry layout and field offsets for the MIPS execution trace buffer.
// MIPS_TRACE_STORE_EN widens each entry with the store strobe, address and write data.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  typedef enum logic [1:0] {
    TRIG_IMM   = 2'd0,
    TRIG_PC    = 2'd1,
    TRIG_STORE = 2'd2,
    TRIG_EXT   = 2'd3
  } trig_mode_e;

  localparam int PC_LSB    = 0;
  localparam int INSTR_LSB = 32;
  localparam int ADDR_LSB  = 64;
  localparam int WD_LSB    = 96;
  localparam int WE_BIT    = 128;

`ifdef MIPS_TRACE_STORE_EN
  localparam int ENTRY_W = 129;
`else
  localparam int ENTRY_W = 64;
`endif

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Trace tap, control, status and drain-port bundle between the core/debug host and the trace buffer.
// master = core/host side, slave = trace buffer.
interface mips_trace_buffer_if
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic [31:0]         pc;
  logic [31:0]         instr;
  logic                mem_we;
  logic [31:0]         mem_addr;
  logic [31:0]         mem_wd;
  logic                cap_en;
  logic                arm;
  logic                abort;
  logic [1:0]          trig_mode;
  logic [31:0]         trig_value;
  logic                trig_in;
  logic [ADDR_W-1:0]   post_count;
  logic                rd_valid;
  logic                rd_ready;
  logic [ENTRY_W-1:0]  rd_data;
  logic [1:0]          state;
  logic                wrapped;

  modport master (
    output pc, instr, mem_we, mem_addr, mem_wd, cap_en, arm, abort,
           trig_mode, trig_value, trig_in, post_count, rd_ready,
    input  rd_valid, rd_data, state, wrapped
  );

  modport slave (
    input  pc, instr, mem_we, mem_addr, mem_wd, cap_en, arm, abort,
           trig_mode, trig_value, trig_in, post_count, rd_ready,
    output rd_valid, rd_data, state, wrapped
  );

endinterface

// File: rtl/mips_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, contents not reset.
module mips_trace_ram #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_trace_buffer.sv
// Circular per-cycle trace of the MIPS fetch/store nets with pre/post-trigger windows, drained oldest-first.
// MIPS_TRACE_STORE_EN adds store fields to each entry and enables the store-address trigger.
module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  mips_trace_buffer_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  trace_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  remain_q, remain_d;
  logic               wrapped_q, wrapped_d;

  logic               sample;
  logic               trig_hit;
  logic               pop;
  logic               rd_valid;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] ram_rdata;

  assign sample   = bus.cap_en && (state_q == ARMED || state_q == POST);
  assign rd_valid = (state_q == DONE) && (count_q != '0);
  assign pop      = rd_valid && bus.rd_ready;

`ifdef MIPS_TRACE_STORE_EN
  // Non-store cycles carry zeroed address/data so stale bus values never look like stores.
  assign wr_entry = {bus.mem_we,
                     bus.mem_we ? bus.mem_wd   : 32'h0,
                     bus.mem_we ? bus.mem_addr : 32'h0,
                     bus.instr, bus.pc};
`else
  logic store_unused;
  assign store_unused = ^{bus.mem_we, bus.mem_addr, bus.mem_wd};
  assign wr_entry     = {bus.instr, bus.pc};
`endif

  always_comb begin
    trig_hit = 1'b0;
    case (trig_mode_e'(bus.trig_mode))
      // Any sample in ARMED is the first one of the run.
      TRIG_IMM:   trig_hit = 1'b1;
      TRIG_PC:    trig_hit = (bus.pc == bus.trig_value);
`ifdef MIPS_TRACE_STORE_EN
      TRIG_STORE: trig_hit = bus.mem_we && (bus.mem_addr == bus.trig_value);
`else
      TRIG_STORE: trig_hit = 1'b0;
`endif
      TRIG_EXT:   trig_hit = bus.trig_in;
      default:    trig_hit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    remain_d  = remain_q;
    wrapped_d = wrapped_q;

    if (bus.abort) begin
      state_d   = IDLE;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      remain_d  = '0;
      wrapped_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            state_d   = ARMED;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
          end
        end
        ARMED, POST: begin
          if (sample) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            // A full buffer drops its oldest entry to make room.
            if (count_q == FULL) begin
              rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
            if (state_q == ARMED) begin
              if (trig_hit) begin
                remain_d = bus.post_count;
                state_d  = (bus.post_count == '0) ? DONE : POST;
              end
            end else begin
              remain_d = remain_q - ADDR_W'(1);
              if (remain_q == ADDR_W'(1)) begin
                state_d = DONE;
              end
            end
          end
        end
        DONE: begin
          if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            count_d  = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      remain_q  <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      remain_q  <= remain_d;
      wrapped_q <= wrapped_d;
    end
  end

  mips_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (sample && !bus.abort),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_valid ? ram_rdata : '0;
  assign bus.state    = state_q;
  assign bus.wrapped  = wrapped_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed self-checking bench for mips_trace_buffer (DEPTH=16); store-field checks run when MIPS_TRACE_STORE_EN is defined.
module tb_mips_trace_buffer;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mips_trace_buffer_if #(.DEPTH(16)) bus ();

  mips_trace_buffer #(.DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic [31:0] p, input logic en);
    bus.pc     = p;
    bus.instr  = p ^ 32'hFFFF_0000;
    bus.cap_en = en;
    tick();
  endtask

  logic [31:0] gap_pcs [5];

  initial begin
    rst            = 1'b0;
    bus.pc         = '0;
    bus.instr      = '0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wd     = '0;
    bus.cap_en     = 1'b0;
    bus.arm        = 1'b0;
    bus.abort      = 1'b0;
    bus.trig_mode  = 2'd0;
    bus.trig_value = '0;
    bus.trig_in    = 1'b0;
    bus.post_count = '0;
    bus.rd_ready   = 1'b0;
    gap_pcs        = '{32'h40, 32'h48, 32'h50, 32'h58, 32'h60};

    tick();
    tick();
    chk("reset_state", bus.state, 2'd0);
    chk("reset_rd_valid", bus.rd_valid, 1'b0);
    chk("reset_rd_data", bus.rd_data, '0);
    chk("reset_wrapped", bus.wrapped, 1'b0);
    rst = 1'b1;
    tick();

    // Immediate trigger, three post-trigger samples
    bus.trig_mode  = 2'd0;
    bus.post_count = 4'd3;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("imm_armed", bus.state, 2'd1);
    smp(32'h0, 1'b1);
    chk("imm_post", bus.state, 2'd2);
    smp(32'h4, 1'b1);
    smp(32'h8, 1'b1);
    chk("imm_still_post", bus.state, 2'd2);
    smp(32'hC, 1'b1);
    bus.cap_en = 1'b0;
    chk("imm_done", bus.state, 2'd3);
    chk("imm_not_wrapped", bus.wrapped, 1'b0);
    chk("imm_first_instr", bus.rd_data[63:32], 32'hFFFF_0000);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("imm_rd_valid", bus.rd_valid, 1'b1);
      chk("imm_rd_pc", bus.rd_data[31:0], 32'(i * 4));
      tick();
    end
    bus.rd_ready = 1'b0;
    chk("imm_drained_valid", bus.rd_valid, 1'b0);
    chk("imm_drained_data", bus.rd_data, '0);
    chk("imm_idle", bus.state, 2'd0);

    // PC trigger after the buffer has wrapped
    bus.trig_mode  = 2'd1;
    bus.trig_value = 32'h100;
    bus.post_count = 4'd4;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 0; i < 64; i++) begin
      smp(32'(i * 4), 1'b1);
    end
    chk("pc_before_trig", bus.state, 2'd1);
    smp(32'h100, 1'b1);
    chk("pc_post", bus.state, 2'd2);
    for (int i = 65; i < 69; i++) begin
      smp(32'(i * 4), 1'b1);
    end
    bus.cap_en = 1'b0;
    chk("pc_done", bus.state, 2'd3);
    chk("pc_wrapped", bus.wrapped, 1'b1);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("pc_rd_valid", bus.rd_valid, 1'b1);
      chk("pc_rd_pc", bus.rd_data[31:0], 32'(32'hD4 + i * 4));
      tick();
    end
    bus.rd_ready = 1'b0;
    chk("pc_drained", bus.rd_valid, 1'b0);
    chk("pc_idle", bus.state, 2'd0);

    // Store-address trigger
    bus.trig_mode  = 2'd2;
    bus.trig_value = 32'h2000;
    bus.post_count = 4'd0;
    bus.arm        = 1'b1;
    tick();
    bus.arm      = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h1234;
    bus.mem_wd   = 32'h5555_5555;
    smp(32'h2FC, 1'b1);
    chk("st_no_trig", bus.state, 2'd1);
    bus.mem_we   = 1'b1;
    bus.mem_addr = 32'h2000;
    bus.mem_wd   = 32'hDEAD_BEEF;
    smp(32'h300, 1'b1);
    bus.mem_we = 1'b0;
    bus.cap_en = 1'b0;
`ifdef MIPS_TRACE_STORE_EN
    chk("st_done", bus.state, 2'd3);
    chk("st_e0_store_fields", bus.rd_data[128:64], '0);
    chk("st_e0_pc", bus.rd_data[31:0], 32'h2FC);
    bus.rd_ready = 1'b1;
    tick();
    chk("st_e1_we", bus.rd_data[128], 1'b1);
    chk("st_e1_addr", bus.rd_data[95:64], 32'h2000);
    chk("st_e1_wd", bus.rd_data[127:96], 32'hDEAD_BEEF);
    chk("st_e1_pc", bus.rd_data[31:0], 32'h300);
    tick();
    bus.rd_ready = 1'b0;
    chk("st_idle", bus.state, 2'd0);
`else
    chk("st_disabled_armed", bus.state, 2'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("st_abort_idle", bus.state, 2'd0);
`endif

    // External trigger with sampling gaps and read backpressure
    bus.trig_mode  = 2'd3;
    bus.post_count = 4'd3;
    bus.arm        = 1'b1;
    tick();
    bus.arm     = 1'b0;
    bus.trig_in = 1'b0;
    smp(32'h40, 1'b1);
    bus.trig_in = 1'b1;
    smp(32'h44, 1'b0);
    chk("gap_no_trig_on_idle_cycle", bus.state, 2'd1);
    smp(32'h48, 1'b1);
    bus.trig_in = 1'b0;
    chk("gap_post", bus.state, 2'd2);
    smp(32'h4C, 1'b0);
    smp(32'h50, 1'b1);
    smp(32'h54, 1'b0);
    smp(32'h58, 1'b1);
    smp(32'h5C, 1'b0);
    chk("gap_still_post", bus.state, 2'd2);
    smp(32'h60, 1'b1);
    chk("gap_done", bus.state, 2'd3);
    for (int i = 0; i < 5; i++) begin
      chk("gap_hold_valid", bus.rd_valid, 1'b1);
      chk("gap_hold_data", bus.rd_data[63:0], {32'hFFFF_0040, 32'h40});
      smp(32'h900 + 32'(i), 1'b1);
    end
    bus.cap_en   = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("gap_rd_pc", bus.rd_data[31:0], gap_pcs[i]);
      tick();
    end
    bus.rd_ready = 1'b0;
    chk("gap_idle", bus.state, 2'd0);

    // Abort in POST beats a simultaneous arm
    bus.trig_mode  = 2'd0;
    bus.post_count = 4'd5;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    smp(32'h500, 1'b1);
    chk("ab_post", bus.state, 2'd2);
    bus.abort = 1'b1;
    bus.arm   = 1'b1;
    smp(32'h504, 1'b1);
    bus.abort  = 1'b0;
    bus.arm    = 1'b0;
    bus.cap_en = 1'b0;
    chk("ab_idle", bus.state, 2'd0);
    chk("ab_no_valid", bus.rd_valid, 1'b0);
    tick();
    chk("ab_arm_ignored", bus.state, 2'd0);
    bus.post_count = 4'd1;
    bus.arm        = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("ab_rearmed", bus.state, 2'd1);
    chk("ab_wrapped_clear", bus.wrapped, 1'b0);
    smp(32'h600, 1'b1);
    smp(32'h604, 1'b1);
    bus.cap_en = 1'b0;
    chk("ab_done", bus.state, 2'd3);
    chk("ab_first_pc", bus.rd_data[31:0], 32'h600);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    chk("ab_second_pc", bus.rd_data[31:0], 32'h604);

    // Asynchronous reset in the middle of readout
    #3;
    rst = 1'b0;
    #1;
    chk("arst_state", bus.state, 2'd0);
    chk("arst_rd_valid", bus.rd_valid, 1'b0);
    chk("arst_rd_data", bus.rd_data, '0);
    chk("arst_wrapped", bus.wrapped, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_stays_idle", bus.state, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
